pipelined_alu: RTL and testbench

//   Parametrised, clocked successor to the 4-bit combinational ALU; it keeps the same 3-bit opcode map.

---
 rtl/pipelined_alu.sv | 190 +++++++++++++++++++
 tb/tb_pipelined_alu.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/pipelined_alu.sv
`timescale 1ns/1ps
// Clocked ALU with valid/ready operand handshake, registered result and flags,
// and a multi-cycle shift-add multiplier returning the full 2*WIDTH-bit product.
module pipelined_alu #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [2:0]       op,
  output logic             out_valid,
  output logic [WIDTH-1:0] result,
  output logic [WIDTH-1:0] result_hi,
  output logic             carry,
  output logic             overflow,
  output logic             zero,
  output logic             busy
);

  localparam int CNT_W = $clog2(WIDTH + 1);
  localparam int MSB   = WIDTH - 1;
  localparam logic [WIDTH-1:0] MIN_VAL = {1'b1, {(WIDTH-1){1'b0}}};

  typedef enum logic [2:0] {
    OP_NEG_A = 3'b000,
    OP_NEG_B = 3'b001,
    OP_ADD   = 3'b010,
    OP_SUB   = 3'b011,
    OP_AND   = 3'b100,
    OP_OR    = 3'b101,
    OP_MUL   = 3'b110,
    OP_XOR   = 3'b111
  } op_e;

  typedef enum logic [0:0] {
    ST_IDLE,
    ST_MUL
  } state_e;

  state_e             state_q,     state_d;
  logic [CNT_W-1:0]   cnt_q,       cnt_d;
  logic [2*WIDTH-1:0] mcand_q,     mcand_d;
  logic [WIDTH-1:0]   mplier_q,    mplier_d;
  logic [2*WIDTH-1:0] acc_q,       acc_d;
  logic [WIDTH-1:0]   result_q,    result_d;
  logic [WIDTH-1:0]   result_hi_q, result_hi_d;
  logic               carry_q,     carry_d;
  logic               overflow_q,  overflow_d;
  logic               zero_q,      zero_d;
  logic               out_valid_q, out_valid_d;

  logic               accept;
  logic [WIDTH:0]     add_ext;
  logic [WIDTH:0]     sub_ext;
  logic [2*WIDTH-1:0] partial;
  logic [WIDTH-1:0]   alu_res;
  logic               alu_carry;
  logic               alu_ovf;

  assign accept  = in_valid && (state_q == ST_IDLE);
  assign add_ext = {1'b0, a} + {1'b0, b};
  assign sub_ext = {1'b0, a} - {1'b0, b};
  assign partial = acc_q + (mplier_q[0] ? mcand_q : '0);

  // Single-cycle operations; the carry column of sub_ext is the borrow.
  always_comb begin
    // NOTE: every output of a combinational block gets a default first so no path can infer a latch.
    alu_res   = '0;
    alu_carry = 1'b0;
    alu_ovf   = 1'b0;
    unique case (op_e'(op))
      OP_NEG_A: begin
        alu_res = ~a + 1'b1;
        alu_ovf = (a == MIN_VAL);
      end
      OP_NEG_B: begin
        alu_res = ~b + 1'b1;
        alu_ovf = (b == MIN_VAL);
      end
      OP_ADD: begin
        alu_res   = add_ext[MSB:0];
        alu_carry = add_ext[WIDTH];
        alu_ovf   = (a[MSB] == b[MSB]) && (add_ext[MSB] != a[MSB]);
      end
      OP_SUB: begin
        alu_res   = sub_ext[MSB:0];
        alu_carry = ~sub_ext[WIDTH];
        alu_ovf   = (a[MSB] != b[MSB]) && (sub_ext[MSB] != a[MSB]);
      end
      OP_AND:  alu_res = a & b;
      OP_OR:   alu_res = a | b;
      OP_XOR:  alu_res = a ^ b;
      default: alu_res = '0;
    endcase
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    mcand_d     = mcand_q;
    mplier_d    = mplier_q;
    acc_d       = acc_q;
    result_d    = result_q;
    result_hi_d = result_hi_q;
    carry_d     = carry_q;
    overflow_d  = overflow_q;
    zero_d      = zero_q;
    out_valid_d = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (accept) begin
          if (op == OP_MUL) begin
            state_d  = ST_MUL;
            acc_d    = '0;
            mcand_d  = {{WIDTH{1'b0}}, a};
            mplier_d = b;
            cnt_d    = CNT_W'(WIDTH);
          end else begin
            out_valid_d = 1'b1;
            result_d    = alu_res;
            result_hi_d = '0;
            carry_d     = alu_carry;
            overflow_d  = alu_ovf;
            zero_d      = (alu_res == '0);
          end
        end
      end
      ST_MUL: begin
        acc_d    = partial;
        mcand_d  = mcand_q << 1;
        mplier_d = mplier_q >> 1;
        cnt_d    = cnt_q - 1'b1;
        // The last partial sum goes straight to the outputs instead of through acc_q.
        if (cnt_q == CNT_W'(1)) begin
          state_d     = ST_IDLE;
          out_valid_d = 1'b1;
          result_d    = partial[WIDTH-1:0];
          result_hi_d = partial[2*WIDTH-1:WIDTH];
          carry_d     = |partial[2*WIDTH-1:WIDTH];
          overflow_d  = 1'b0;
          zero_d      = (partial == '0);
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so all registers update together at the edge.
    if (reset) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      mcand_q     <= '0;
      mplier_q    <= '0;
      acc_q       <= '0;
      result_q    <= '0;
      result_hi_q <= '0;
      carry_q     <= 1'b0;
      overflow_q  <= 1'b0;
      zero_q      <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      mcand_q     <= mcand_d;
      mplier_q    <= mplier_d;
      acc_q       <= acc_d;
      result_q    <= result_d;
      result_hi_q <= result_hi_d;
      carry_q     <= carry_d;
      overflow_q  <= overflow_d;
      zero_q      <= zero_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign in_ready  = (state_q == ST_IDLE);
  assign busy      = (state_q == ST_MUL);
  assign out_valid = out_valid_q;
  assign result    = result_q;
  assign result_hi = result_hi_q;
  assign carry     = carry_q;
  assign overflow  = overflow_q;
  assign zero      = zero_q;

endmodule

// File: tb/tb_pipelined_alu.sv
`timescale 1ns/1ps
// Self-checking bench for pipelined_alu (WIDTH=8): directed vector table,
// hand-written handshake/reset sequences, and random ops against an arithmetic model.
module tb_pipelined_alu;

  localparam int W = 8;
  localparam int M = 1 << W;

  logic         clk = 1'b0;
  logic         reset;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] a, b;
  logic [2:0]   op;
  logic         out_valid;
  logic [W-1:0] result, result_hi;
  logic         carry, overflow, zero, busy;

  int n_cmp  = 0;
  int n_fail = 0;

  pipelined_alu #(.WIDTH(W)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .op(op), .out_valid(out_valid), .result(result),
    .result_hi(result_hi), .carry(carry), .overflow(overflow),
    .zero(zero), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [2:0]   op;
    logic [W-1:0] a, b;
    logic [W-1:0] r, rh;
    logic         c, ov, z;
    int           lat;
  } vec_t;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Advance to 1 time unit after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference: plain integer arithmetic on the operand values.
  function automatic vec_t model(input logic [2:0] o, input logic [W-1:0] xa, input logic [W-1:0] xb);
    vec_t v;
    int ua, ub, sa, sb, s, p;
    ua = int'(xa); ub = int'(xb);
    sa = (ua >= M/2) ? ua - M : ua;
    sb = (ub >= M/2) ? ub - M : ub;
    v.op = o; v.a = xa; v.b = xb;
    v.r = '0; v.rh = '0; v.c = 1'b0; v.ov = 1'b0; v.lat = 1;
    case (o)
      3'b000: begin v.r = W'((M - ua) % M); v.ov = (ua == M/2); end
      3'b001: begin v.r = W'((M - ub) % M); v.ov = (ub == M/2); end
      3'b010: begin
        s = ua + ub; v.r = W'(s % M); v.c = (s >= M);
        s = sa + sb; v.ov = (s > M/2 - 1) || (s < -M/2);
      end
      3'b011: begin
        v.r = W'((ua - ub + M) % M); v.c = (ua >= ub);
        s = sa - sb; v.ov = (s > M/2 - 1) || (s < -M/2);
      end
      3'b100: v.r = xa & xb;
      3'b101: v.r = xa | xb;
      3'b110: begin
        p = ua * ub; v.r = W'(p % M); v.rh = W'(p / M); v.c = (p >= M); v.lat = W + 1;
      end
      default: v.r = xa ^ xb;
    endcase
    v.z = (v.r == 0) && (v.rh == 0);
    return v;
  endfunction

  // Issue one op (caller ensures in_ready) and wait, bounded, for its out_valid.
  task automatic run_op(input vec_t v, input string tag);
    int lat;
    a = v.a; b = v.b; op = v.op; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    lat = 1;
    while (!out_valid && lat < 40) begin
      tick();
      lat++;
    end
    check({tag, ".latency"},   64'(lat),       64'(v.lat));
    check({tag, ".result"},    64'(result),    64'(v.r));
    check({tag, ".result_hi"}, 64'(result_hi), 64'(v.rh));
    check({tag, ".carry"},     64'(carry),     64'(v.c));
    check({tag, ".overflow"},  64'(overflow),  64'(v.ov));
    check({tag, ".zero"},      64'(zero),      64'(v.z));
  endtask

  vec_t vecs[15];
  vec_t rv;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    //           op      a      b      r      rh     c     ov    z     lat
    vecs[0]  = '{3'b010, 8'hF0, 8'h20, 8'h10, 8'h00, 1'b1, 1'b0, 1'b0, 1};
    vecs[1]  = '{3'b011, 8'h05, 8'h03, 8'h02, 8'h00, 1'b1, 1'b0, 1'b0, 1};
    vecs[2]  = '{3'b011, 8'h03, 8'h05, 8'hFE, 8'h00, 1'b0, 1'b0, 1'b0, 1};
    vecs[3]  = '{3'b010, 8'h7F, 8'h01, 8'h80, 8'h00, 1'b0, 1'b1, 1'b0, 1};
    vecs[4]  = '{3'b000, 8'h80, 8'h00, 8'h80, 8'h00, 1'b0, 1'b1, 1'b0, 1};
    vecs[5]  = '{3'b001, 8'h55, 8'h00, 8'h00, 8'h00, 1'b0, 1'b0, 1'b1, 1};
    vecs[6]  = '{3'b100, 8'h0C, 8'h0A, 8'h08, 8'h00, 1'b0, 1'b0, 1'b0, 1};
    vecs[7]  = '{3'b101, 8'h0C, 8'h0A, 8'h0E, 8'h00, 1'b0, 1'b0, 1'b0, 1};
    vecs[8]  = '{3'b111, 8'h0C, 8'h0A, 8'h06, 8'h00, 1'b0, 1'b0, 1'b0, 1};
    vecs[9]  = '{3'b110, 8'hFF, 8'hFF, 8'h01, 8'hFE, 1'b1, 1'b0, 1'b0, 9};
    vecs[10] = '{3'b110, 8'h0F, 8'h11, 8'hFF, 8'h00, 1'b0, 1'b0, 1'b0, 9};
    vecs[11] = '{3'b110, 8'h00, 8'h37, 8'h00, 8'h00, 1'b0, 1'b0, 1'b1, 9};
    vecs[12] = '{3'b000, 8'h00, 8'h00, 8'h00, 8'h00, 1'b0, 1'b0, 1'b1, 1};
    vecs[13] = '{3'b011, 8'h80, 8'h01, 8'h7F, 8'h00, 1'b1, 1'b1, 1'b0, 1};
    vecs[14] = '{3'b010, 8'hFF, 8'h01, 8'h00, 8'h00, 1'b1, 1'b0, 1'b1, 1};

    reset = 1'b1; in_valid = 1'b0; a = '0; b = '0; op = '0;
    repeat (2) @(posedge clk);
    #1;
    check("rst.in_ready",  64'(in_ready),  64'd1);
    check("rst.out_valid", 64'(out_valid), 64'd0);
    check("rst.result",    64'(result),    64'd0);
    check("rst.result_hi", 64'(result_hi), 64'd0);
    check("rst.flags",     64'({carry, overflow, zero}), 64'd0);
    check("rst.busy",      64'(busy),      64'd0);
    reset = 1'b0;
    tick();

    foreach (vecs[i]) run_op(vecs[i], $sformatf("vec%0d", i));

    // Back-to-back logic ops, one result per cycle.
    tick();
    a = 8'h0C; b = 8'h0A; op = 3'b100; in_valid = 1'b1;
    tick();
    check("b2b.and.valid", 64'(out_valid), 64'd1);
    check("b2b.and",       64'(result),    64'h08);
    op = 3'b101;
    tick();
    check("b2b.or.valid",  64'(out_valid), 64'd1);
    check("b2b.or",        64'(result),    64'h0E);
    op = 3'b111;
    tick();
    check("b2b.xor.valid", 64'(out_valid), 64'd1);
    check("b2b.xor",       64'(result),    64'h06);
    in_valid = 1'b0;
    tick();
    check("b2b.pulse_end", 64'(out_valid), 64'd0);

    // Multiply with in_valid pulses during busy that must be ignored.
    a = 8'hFF; b = 8'hFF; op = 3'b110; in_valid = 1'b1;
    tick();
    for (int i = 1; i <= 8; i++) begin
      check($sformatf("mulbusy%0d.in_ready", i), 64'(in_ready), 64'd0);
      check($sformatf("mulbusy%0d.busy", i),     64'(busy),     64'd1);
      check($sformatf("mulbusy%0d.valid", i),    64'(out_valid), 64'd0);
      a = 8'h01; b = 8'h01; op = 3'b010; in_valid = (i % 2 == 1);
      tick();
    end
    in_valid = 1'b0;
    check("mulbusy.done.valid", 64'(out_valid), 64'd1);
    check("mulbusy.done.ready", 64'(in_ready),  64'd1);
    check("mulbusy.result",     64'(result),    64'h01);
    check("mulbusy.result_hi",  64'(result_hi), 64'hFE);
    check("mulbusy.carry",      64'(carry),     64'd1);
    tick();
    check("mulbusy.pulse_end",  64'(out_valid), 64'd0);

    // Reset during cycle 4 of a multiply aborts it.
    a = 8'h0F; b = 8'h11; op = 3'b110; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    repeat (3) tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("abort.in_ready",  64'(in_ready),  64'd1);
    check("abort.busy",      64'(busy),      64'd0);
    check("abort.out_valid", 64'(out_valid), 64'd0);
    check("abort.result",    64'(result),    64'd0);
    begin
      int seen = 0;
      for (int i = 0; i < 12; i++) begin
        tick();
        if (out_valid) seen++;
      end
      check("abort.no_valid", 64'(seen), 64'd0);
    end
    run_op(vecs[10], "after_abort");

    // Reset wins over a simultaneous accept.
    a = 8'h01; b = 8'h01; op = 3'b010; in_valid = 1'b1; reset = 1'b1;
    tick();
    reset = 1'b0; in_valid = 1'b0;
    check("rst_dom.out_valid", 64'(out_valid), 64'd0);
    tick();
    check("rst_dom.no_late",   64'(out_valid), 64'd0);
    check("rst_dom.result",    64'(result),    64'd0);

    // Random ops against the model.
    for (int i = 0; i < 300; i++) begin
      rv = model(3'($urandom_range(7)), W'($urandom), W'($urandom));
      run_op(rv, $sformatf("rnd%0d.op%0d", i, rv.op));
      if ($urandom_range(3) == 0) tick();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
